// File: rtl/txrxmem_arbiter.sv
// Two-port arbiter for the single-port tx/rx buffer RAM: burst-limited round-robin,
// registered RAM command, and read data steered back to the port that issued the read.
module txrxmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAXBURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAXBURST);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic            ram_we_q, ram_we_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic            rd_vld_p0_q, rd_vld_p0_d;
  owner_e          rd_id_p0_q, rd_id_p0_d;
  logic            rd_vld_p1_q, rd_vld_p1_d;
  owner_e          rd_id_p1_q, rd_id_p1_d;

  logic            gnt_any;
  owner_e          gnt_sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt >= MAX_C) ? MAX_C : cnt + CW'(1);
  endfunction

  function automatic owner_e other_port(input owner_e own);
    return (own == OWN_A) ? OWN_B : OWN_A;
  endfunction

  // Grant decision: owner keeps the RAM under contention until its burst is used up
  always_comb begin
    gnt_any     = 1'b0;
    gnt_sel     = owner_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!reset && (a_req || b_req)) begin
      gnt_any = 1'b1;
      if (a_req && b_req) begin
        gnt_sel = (burst_cnt_q < MAX_C) ? owner_q : other_port(owner_q);
      end else begin
        gnt_sel = a_req ? OWN_A : OWN_B;
      end
      if (gnt_sel == owner_q) begin
        burst_cnt_d = sat_inc(burst_cnt_q);
      end else begin
        owner_d     = gnt_sel;
        burst_cnt_d = CW'(1);
      end
    end
  end

  assign a_gnt = gnt_any && (gnt_sel == OWN_A);
  assign b_gnt = gnt_any && (gnt_sel == OWN_B);

  // Command stage: load the winner's fields; address/data hold when idle
  always_comb begin
    sel_we      = (gnt_sel == OWN_A) ? a_we    : b_we;
    sel_addr    = (gnt_sel == OWN_A) ? a_addr  : b_addr;
    sel_wdata   = (gnt_sel == OWN_A) ? a_wdata : b_wdata;
    ram_we_d    = gnt_any && sel_we;
    ram_addr_d  = gnt_any ? sel_addr  : ram_addr_q;
    ram_wdata_d = gnt_any ? sel_wdata : ram_wdata_q;
    rd_vld_p0_d = gnt_any && !sel_we;
    rd_id_p0_d  = gnt_sel;
    rd_vld_p1_d = rd_vld_p0_q;
    rd_id_p1_d  = rd_id_p0_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_A;
      burst_cnt_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rd_vld_p0_q <= 1'b0;
      rd_id_p0_q  <= OWN_A;
      rd_vld_p1_q <= 1'b0;
      rd_id_p1_q  <= OWN_A;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rd_vld_p0_q <= rd_vld_p0_d;
      rd_id_p0_q  <= rd_id_p0_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      rd_id_p1_q  <= rd_id_p1_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

  // Read return: the RAM's synchronous output lines up with the second tag stage
  assign a_rvalid = rd_vld_p1_q && (rd_id_p1_q == OWN_A);
  assign b_rvalid = rd_vld_p1_q && (rd_id_p1_q == OWN_B);
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_txrxmem_arbiter.sv
// Bench for txrxmem_arbiter: RAM model, behavioural arbitration/scoreboard model,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_txrxmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MAXBURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  txrxmem_arbiter #(.AW(AW), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a known initial pattern: mem[i] = i ^ 0x5A
  logic [DW-1:0] ram_mem [1<<AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'(i) ^ 8'h5A;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arbitration state, expected RAM command, and in-flight reads
  int            m_owner, m_cnt;
  logic [DW-1:0] m_mem [1<<AW];
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            e_v0, e_v1;
  int            e_p0, e_p1;
  logic [DW-1:0] e_d0, e_d1;
  bit            started = 0;

  initial for (int i = 0; i < (1 << AW); i++) m_mem[i] = DW'(i) ^ 8'h5A;

  always @(negedge clk) begin
    int g;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    if (reset) begin
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      m_owner = 0; m_cnt = 0;
      e_we = 0; e_addr = '0; e_wdata = '0;
      e_v0 = 0; e_v1 = 0; e_p0 = 0; e_p1 = 0; e_d0 = '0; e_d1 = '0;
      started = 1;
    end else if (started) begin
      g = -1;
      if (a_req && b_req) g = (m_cnt < MAXBURST) ? m_owner : 1 - m_owner;
      else if (a_req) g = 0;
      else if (b_req) g = 1;
      chk("a_gnt", a_gnt, (g == 0));
      chk("b_gnt", b_gnt, (g == 1));
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
      chk("a_rvalid", a_rvalid, (e_v1 && e_p1 == 0));
      chk("b_rvalid", b_rvalid, (e_v1 && e_p1 == 1));
      if (e_v1 && e_p1 == 0) chk("a_rdata", a_rdata, e_d1);
      if (e_v1 && e_p1 == 1) chk("b_rdata", b_rdata, e_d1);
      e_v1 = e_v0; e_p1 = e_p0; e_d1 = e_d0;
      e_v0 = 0;
      e_we = 0;
      if (g >= 0) begin
        g_we    = (g == 0) ? a_we : b_we;
        g_addr  = (g == 0) ? a_addr : b_addr;
        g_wdata = (g == 0) ? a_wdata : b_wdata;
        if (g == m_owner) m_cnt = (m_cnt >= MAXBURST) ? MAXBURST : m_cnt + 1;
        else begin m_owner = g; m_cnt = 1; end
        e_we = g_we; e_addr = g_addr; e_wdata = g_wdata;
        if (g_we) m_mem[g_addr] = g_wdata;
        else begin e_v0 = 1; e_p0 = g; e_d0 = m_mem[g_addr]; end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
  endtask

  bit ga, gb;
  int ngnt;

  initial begin
    reset = 1; idle();
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) cycle();
    reset = 0;

    // 1: single A read of 0x005
    a_req = 1; a_we = 0; a_addr = 10'h005;
    @(negedge clk); chk("t1_a_gnt", a_gnt, 1); chk("t1_b_gnt", b_gnt, 0);
    cycle(); idle();
    @(negedge clk); chk("t1_ram_addr", ram_addr, 10'h005); chk("t1_ram_we", ram_we, 0);
    cycle();
    @(negedge clk); chk("t1_a_rvalid", a_rvalid, 1); chk("t1_a_rdata", a_rdata, 8'h5F);
    chk("t1_b_rvalid", b_rvalid, 0);
    cycle();

    // 2: B writes 0xA5 to 0x010, A reads it back next cycle
    b_req = 1; b_we = 1; b_addr = 10'h010; b_wdata = 8'hA5;
    @(negedge clk); chk("t2_b_gnt", b_gnt, 1);
    cycle(); idle(); a_req = 1; a_we = 0; a_addr = 10'h010;
    @(negedge clk); chk("t2_a_gnt", a_gnt, 1);
    chk("t2_ram_we", ram_we, 1); chk("t2_ram_wdata", ram_wdata, 8'hA5);
    cycle(); idle();
    cycle();
    @(negedge clk); chk("t2_a_rvalid", a_rvalid, 1); chk("t2_a_rdata", a_rdata, 8'hA5);
    cycle();

    // 3: continuous contention from reset state
    reset = 1; cycle(); reset = 0;
    a_req = 1; a_we = 0; a_addr = 10'h020; b_req = 1; b_we = 0; b_addr = 10'h021;
    ngnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_a_gnt", a_gnt, ((i / 4) % 2 == 0));
      chk("t3_b_gnt", b_gnt, ((i / 4) % 2 == 1));
      if (a_gnt || b_gnt) ngnt++;
      cycle();
    end
    chk("t3_total", ngnt, 20);
    idle(); cycle(); cycle();

    // 4: B alone for 10 cycles, then A joins while B still requests
    reset = 1; cycle(); reset = 0;
    b_req = 1; b_we = 0; b_addr = 10'h030;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("t4_b_gnt", b_gnt, 1);
      cycle();
    end
    a_req = 1; a_we = 0; a_addr = 10'h031;
    @(negedge clk); chk("t4_a_gnt", a_gnt, 1); chk("t4_b_wait", b_gnt, 0);
    cycle(); idle(); cycle(); cycle();

    // 5: four back-to-back A reads of 0x000..0x003
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin a_req = 1; a_we = 0; a_addr = AW'(k); end else a_req = 0;
      @(negedge clk);
      if (k < 4) chk("t5_a_gnt", a_gnt, 1);
      if (k >= 2) begin
        chk("t5_a_rvalid", a_rvalid, 1);
        chk("t5_a_rdata", a_rdata, DW'(k - 2) ^ 8'h5A);
      end
      cycle();
    end
    idle(); cycle();

    // 6: reset the cycle after a read grant
    a_req = 1; a_we = 0; a_addr = 10'h007;
    @(negedge clk); chk("t6_a_gnt", a_gnt, 1);
    cycle(); idle(); reset = 1;
    cycle(); reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t6_no_rvalid", a_rvalid, 0); chk("t6_ram_we", ram_we, 0);
      cycle();
    end
    a_req = 1; b_req = 1; a_addr = 10'h008; b_addr = 10'h009;
    @(negedge clk); chk("t6_first_a", a_gnt, 1); chk("t6_first_b", b_gnt, 0);
    cycle(); idle(); cycle(); cycle();

    // Randomized traffic on a small address window, with occasional resets and withdrawals
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); ga = a_gnt; gb = b_gnt;
      cycle();
      reset = ($urandom_range(0, 199) == 0);
      if (!a_req || ga) begin
        a_req = ($urandom_range(0, 99) < 60); a_we = $urandom_range(0, 1);
        a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
      end else if ($urandom_range(0, 99) < 5) a_req = 0;
      if (!b_req || gb) begin
        b_req = ($urandom_range(0, 99) < 60); b_we = $urandom_range(0, 1);
        b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
      end else if ($urandom_range(0, 99) < 5) b_req = 0;
    end
    reset = 0; idle();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
